// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths and the request bundle used by the decoder, the register bank and operand fetch.
package operand_fetch_pkg;
    localparam int OPF_DATA_W = 8;
    localparam int OPF_ADDR_W = 3;
    localparam int OPF_TAG_W  = 4;

    typedef struct packed {
        logic [OPF_ADDR_W-1:0] rs1;
        logic [OPF_ADDR_W-1:0] rs2;
        logic [OPF_ADDR_W-1:0] rd;
        logic                  rs1_en;
        logic                  rs2_en;
        logic                  rd_en;
        logic [OPF_TAG_W-1:0]  tag;
    } opf_req_t;
endpackage

// File: rtl/opf_scoreboard.sv
// opf_scoreboard: per-register pending bits with blocked/busy lookups for two sources and a destination.
// OPFETCH_BYPASS_EN: a same-cycle writeback unblocks a pending source.
module opf_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = OPF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_en,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              blocked1,
    output logic              blocked2,
    output logic              rd_busy
);
    localparam int N = 2**ADDR_W;
`ifdef OPFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic [N-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (wb_we) pending_d[wb_addr] = 1'b0;
        // a new destination claim outranks the retiring writeback to the same register
        if (accept && rd_en) pending_d[rd] = 1'b1;
        blocked1 = pending_q[rs1] & ~(BYP & wb_we & (wb_addr == rs1));
        blocked2 = pending_q[rs2] & ~(BYP & wb_we & (wb_addr == rs2));
        rd_busy  = pending_q[rd] & ~(wb_we & (wb_addr == rd));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: hazard-checked operand read from the register bank into a valid/ready output stage.
// OPFETCH_BYPASS_EN: forward same-cycle writeback data into the operands.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = OPF_DATA_W,
    parameter int ADDR_W = OPF_ADDR_W,
    parameter int TAG_W  = OPF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic              req_rs1_en,
    input  logic              req_rs2_en,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_rd_en,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] rf_addr_rd1,
    output logic [ADDR_W-1:0] rf_addr_rd2,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_din,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd,
    output logic              op_rd_en,
    output logic [TAG_W-1:0]  op_tag,
    output logic [7:0]        stall_cnt
);
    logic              blocked1, blocked2, rd_busy, accept, hit1, hit2;
    logic              op_valid_q, op_valid_d, op_rd_en_q, op_rd_en_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sel_a, sel_b;
    logic [ADDR_W-1:0] op_rd_q, op_rd_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic [7:0]        stall_q, stall_d;

    opf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept),
        .rs1      (req_rs1),
        .rs2      (req_rs2),
        .rd       (req_rd),
        .rd_en    (req_rd_en),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .blocked1 (blocked1),
        .blocked2 (blocked2),
        .rd_busy  (rd_busy)
    );

`ifdef OPFETCH_BYPASS_EN
    assign hit1 = wb_we & (wb_addr == req_rs1);
    assign hit2 = wb_we & (wb_addr == req_rs2);
`else
    logic unused_wb_din;
    assign unused_wb_din = ^wb_din;
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign rf_addr_rd1 = req_rs1;
    assign rf_addr_rd2 = req_rs2;

    always_comb begin
        req_ready  = ~((req_rs1_en & blocked1) | (req_rs2_en & blocked2) | (req_rd_en & rd_busy))
                     & (~op_valid_q | op_ready);
        accept     = req_valid & req_ready;
        sel_a      = !req_rs1_en ? '0 : hit1 ? wb_din : rf_dout1;
        sel_b      = !req_rs2_en ? '0 : hit2 ? wb_din : rf_dout2;
        op_valid_d = accept ? 1'b1 : op_ready ? 1'b0 : op_valid_q;
        op_a_d     = accept ? sel_a : op_a_q;
        op_b_d     = accept ? sel_b : op_b_q;
        op_rd_d    = accept ? req_rd : op_rd_q;
        op_rd_en_d = accept ? req_rd_en : op_rd_en_q;
        op_tag_d   = accept ? req_tag : op_tag_q;
        stall_d    = (req_valid && !req_ready && stall_q != 8'hFF) ? stall_q + 8'd1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_rd_en_q <= 1'b0;
            op_tag_q   <= '0;
            stall_q    <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rd_q    <= op_rd_d;
            op_rd_en_q <= op_rd_en_d;
            op_tag_q   <= op_tag_d;
            stall_q    <= stall_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_rd     = op_rd_q;
    assign op_rd_en  = op_rd_en_q;
    assign op_tag    = op_tag_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios against operand_fetch with a behavioural 8x8 register bank.
module tb_operand_fetch;
`ifdef OPFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic       req_rs1_en = 1'b0, req_rs2_en = 1'b0, req_rd_en = 1'b0;
    logic [3:0] req_tag = '0;
    logic [2:0] rf_addr_rd1, rf_addr_rd2;
    logic [7:0] rf_dout1, rf_dout2;
    logic       wb_we = 1'b0;
    logic [2:0] wb_addr = '0;
    logic [7:0] wb_din = '0;
    logic       op_valid, op_ready = 1'b1, op_rd_en;
    logic [7:0] op_a, op_b, stall_cnt;
    logic [2:0] op_rd;
    logic [3:0] op_tag;
    logic [7:0] bank [8];
    int         tests = 0, fails = 0;
    int         exp_stall = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (wb_we) bank[wb_addr] <= wb_din;
    assign rf_dout1 = bank[rf_addr_rd1];
    assign rf_dout2 = bank[rf_addr_rd2];

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs1_en(req_rs1_en), .req_rs2_en(req_rs2_en),
        .req_rd(req_rd), .req_rd_en(req_rd_en), .req_tag(req_tag),
        .rf_addr_rd1(rf_addr_rd1), .rf_addr_rd2(rf_addr_rd2), .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_din(wb_din),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_rd_en(op_rd_en), .op_tag(op_tag), .stall_cnt(stall_cnt)
    );

    task set_req(input logic v, input logic [2:0] s1, input logic e1, input logic [2:0] s2,
                 input logic e2, input logic [2:0] d, input logic de, input logic [3:0] t);
        req_valid = v; req_rs1 = s1; req_rs1_en = e1; req_rs2 = s2; req_rs2_en = e2;
        req_rd = d; req_rd_en = de; req_tag = t;
    endtask

    // reset cycles also preload the bank: the writebacks must not touch the scoreboard
    task test_reset;
        @(negedge clk); wb_we = 1'b1; wb_addr = 3'd3; wb_din = 8'h5A;
        @(negedge clk); wb_addr = 3'd4; wb_din = 8'h11;
        @(negedge clk); wb_we = 1'b0;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        tests++; if (op_a !== 8'd0 || op_b !== 8'd0) begin fails++; $display("FAIL reset_ops got %h/%h want 00/00", op_a, op_b); end
        tests++; if (op_tag !== 4'd0 || op_rd_en !== 1'b0 || op_rd !== 3'd0) begin fails++; $display("FAIL reset_fields got tag=%h rd=%0d rd_en=%b want 0", op_tag, op_rd, op_rd_en); end
        rst_n = 1'b1; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task test_basic;
        @(negedge clk); set_req(1, 3'd3, 1, 3'd4, 1, 3'd5, 1, 4'd9); #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %b want 1", req_ready); end
        tests++; if (rf_addr_rd1 !== 3'd3 || rf_addr_rd2 !== 3'd4) begin fails++; $display("FAIL basic_rf_addr got %0d/%0d want 3/4", rf_addr_rd1, rf_addr_rd2); end
        @(posedge clk); #1;
        tests++; if (op_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", op_valid); end
        tests++; if (op_a !== 8'h5A || op_b !== 8'h11) begin fails++; $display("FAIL basic_ops got %h/%h want 5a/11", op_a, op_b); end
        tests++; if (op_rd !== 3'd5 || op_rd_en !== 1'b1 || op_tag !== 4'd9) begin fails++; $display("FAIL basic_fields got rd=%0d en=%b tag=%0d want 5/1/9", op_rd, op_rd_en, op_tag); end
    endtask

    task test_raw;
        @(negedge clk); set_req(1, 3'd5, 1, 3'd3, 0, 3'd0, 0, 4'd1); #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL raw_stall_ready got %b want 0", req_ready); end
        repeat (2) @(posedge clk); #1;
        exp_stall = 2;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL raw_drain got %b want 0", op_valid); end
        tests++; if (stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk); wb_we = 1'b1; wb_addr = 3'd5; wb_din = 8'hC3; #1;
        tests++; if (req_ready !== BYP) begin fails++; $display("FAIL raw_wb_ready got %b want %b", req_ready, BYP); end
        if (!BYP) begin
            @(posedge clk); exp_stall++;
            @(negedge clk); wb_we = 1'b0; #1;
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL raw_after_wb_ready got %b want 1", req_ready); end
        end
        @(posedge clk); #1;
        tests++; if (op_valid !== 1'b1 || op_a !== 8'hC3 || op_b !== 8'h00) begin fails++; $display("FAIL raw_ops got v=%b %h/%h want 1 c3/00", op_valid, op_a, op_b); end
        tests++; if (op_tag !== 4'd1 || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL raw_tag_stall got tag=%0d stall=%0d want 1/%0d", op_tag, stall_cnt, exp_stall); end
        @(negedge clk); wb_we = 1'b0; req_valid = 1'b0;
    endtask

    task test_back_to_back;
        op_ready = 1'b0; set_req(1, 3'd3, 1, 3'd4, 1, 3'd0, 0, 4'd2); #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got %b want 0", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; exp_stall++;
            tests++; if (op_valid !== 1'b1 || op_a !== 8'hC3 || op_tag !== 4'd1 || req_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%b a=%h tag=%0d rdy=%b want 1 c3 1 0", i, op_valid, op_a, op_tag, req_ready);
            end
        end
        tests++; if (stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL bp_stall got %0d want %0d", stall_cnt, exp_stall); end
        @(negedge clk); op_ready = 1'b1; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        tests++; if (op_a !== 8'h5A || op_b !== 8'h11 || op_tag !== 4'd2 || stall_cnt !== 8'(exp_stall)) begin
            fails++; $display("FAIL bp_next got %h/%h tag=%0d stall=%0d want 5a/11 2 %0d", op_a, op_b, op_tag, stall_cnt, exp_stall);
        end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task test_waw;
        set_req(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 4'd3); #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL waw_first_ready got %b want 1", req_ready); end
        @(negedge clk); req_tag = 4'd4; wb_we = 1'b1; wb_addr = 3'd2; wb_din = 8'h77; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL waw_clear_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        tests++; if (op_tag !== 4'd4 || op_rd !== 3'd2) begin fails++; $display("FAIL waw_accept got tag=%0d rd=%0d want 4/2", op_tag, op_rd); end
        @(negedge clk); wb_we = 1'b0; req_valid = 1'b0; #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL waw_set_wins got %b want 0", req_ready); end
        set_req(0, 3'd2, 1, 3'd0, 0, 3'd0, 0, 4'd0); #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL waw_raw_r2 got %b want 0", req_ready); end
        @(negedge clk); wb_we = 1'b1; wb_addr = 3'd2; wb_din = 8'h66; #1;
        tests++; if (req_ready !== BYP) begin fails++; $display("FAIL waw_wb_ready got %b want %b", req_ready, BYP); end
        @(negedge clk); wb_we = 1'b0; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL waw_cleared got %b want 1", req_ready); end
    endtask

    task test_reset_mid;
        @(negedge clk); op_ready = 1'b1; set_req(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 4'd7);
        @(negedge clk); op_ready = 1'b0; set_req(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 4'd8); #1;
        tests++; if (req_ready !== 1'b0 || op_valid !== 1'b1) begin fails++; $display("FAIL mid_setup got rdy=%b v=%b want 0/1", req_ready, op_valid); end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (op_valid !== 1'b0 || stall_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset got v=%b stall=%0d want 0/0", op_valid, stall_cnt); end
        tests++; if (op_rd !== 3'd0 || op_rd_en !== 1'b0 || op_a !== 8'd0 || op_tag !== 4'd0) begin
            fails++; $display("FAIL mid_reset_fields got rd=%0d en=%b a=%h tag=%0d want 0", op_rd, op_rd_en, op_a, op_tag);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        tests++; if (op_valid !== 1'b1 || op_a !== 8'hC3 || op_tag !== 4'd8) begin fails++; $display("FAIL mid_accept got v=%b a=%h tag=%0d want 1 c3 8", op_valid, op_a, op_tag); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task test_stall_sat;
        op_ready = 1'b1; set_req(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 4'd9);
        @(negedge clk); set_req(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 4'd10);
        repeat (300) @(posedge clk); #1;
        tests++; if (stall_cnt !== 8'd255 || req_ready !== 1'b0) begin fails++; $display("FAIL stall_sat got %0d rdy=%b want 255/0", stall_cnt, req_ready); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_raw;
        test_back_to_back;
        test_waw;
        test_reset_mid;
        test_stall_sat;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
